vga_text_ctrl: RTL and testbench

- Text-mode console controller sitting between the keyboard/character source, the VGA timing generator and the 9x16 font ROM.
- Owns a COLS x ROWS character buffer and a write cursor, and accepts characters over a valid/ready handshake.
- For every pixel the timing generator presents, it looks up the character, drives the font ROM, and outputs pixel colour with fixed latency.
- Handles newline, backspace, line wrap, scroll-up and a blinking cursor.

---
 rtl/vga_text_pkg.sv | 21 ++
 rtl/vga_text_buf.sv | 44 ++++
 rtl/vga_text_ctrl.sv | 247 ++++++++++++++++++++++++
 tb/tb_vga_text_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_text_pkg.sv
// Shared types and constants for the text-mode VGA console controller.
package vga_text_pkg;

  typedef enum logic [2:0] {
    CLEAR   = 3'd0,
    IDLE    = 3'd1,
    SC_RD   = 3'd2,
    SC_WR   = 3'd3,
    SC_FILL = 3'd4
  } state_t;

  localparam logic [7:0] CH_SPACE    = 8'h20;
  localparam logic [7:0] CH_LF       = 8'h0A;
  localparam logic [7:0] CH_CR       = 8'h0D;
  localparam logic [7:0] CH_BS       = 8'h08;
  localparam logic [7:0] CH_PRINT_HI = 8'h7E;

  localparam int CELL_W = 9;
  localparam int CELL_H = 16;

endpackage

// File: rtl/vga_text_buf.sv
// Dual-port character RAM: port A is the render read port, port B belongs to
// the controller. Both reads are synchronous.
module vga_text_buf
  import vga_text_pkg::*;
#(
  parameter int DEPTH = 2100,
  parameter int AW    = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] a_addr_i,
  output logic [7:0]    a_data_o,
  input  logic [AW-1:0] b_addr_i,
  input  logic          b_we_i,
  input  logic [7:0]    b_wdata_i,
  output logic [7:0]    b_rdata_o
);

  logic [7:0] mem_q [DEPTH];
  logic [7:0] a_data_q;
  logic [7:0] b_rdata_q;

  // Storage array has no reset; CLEAR initialises it after every reset.
  always_ff @(posedge clk) begin
    if (b_we_i) begin
      mem_q[b_addr_i] <= b_wdata_i;
    end
  end

  // Read registers reset to zero so font_ascii starts at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_data_q  <= 8'h00;
      b_rdata_q <= 8'h00;
    end else begin
      a_data_q  <= mem_q[a_addr_i];
      b_rdata_q <= mem_q[b_addr_i];
    end
  end

  assign a_data_o  = a_data_q;
  assign b_rdata_o = b_rdata_q;

endmodule

// File: rtl/vga_text_ctrl.sv
// Text console: character buffer, write cursor with newline/backspace/wrap/
// scroll, and a fixed two-cycle render pipeline towards the font ROM.
module vga_text_ctrl
  import vga_text_pkg::*;
#(
  parameter int          COLS         = 70,
  parameter int          ROWS         = 30,
  parameter logic [23:0] FG_RGB       = 24'hFFFFFF,
  parameter logic [23:0] BG_RGB       = 24'h000000,
  parameter int          BLINK_CYCLES = 25000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [7:0]  in_char,
  output logic        in_ready,
  input  logic [9:0]  h_addr,
  input  logic [9:0]  v_addr,
  input  logic        pix_valid,
  output logic [7:0]  font_ascii,
  output logic [3:0]  font_row,
  output logic [3:0]  font_col,
  input  logic        font_bit,
  output logic [23:0] rgb,
  output logic        rgb_valid
);

  localparam int CELLS = COLS * ROWS;
  localparam int AW    = $clog2(CELLS);
  localparam int RW    = $clog2(ROWS);
  localparam int CW    = $clog2(COLS);
  localparam int BW    = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [AW-1:0] LAST_CELL   = AW'(CELLS - 1);
  localparam logic [AW-1:0] SCROLL_LAST = AW'(CELLS - COLS - 1);

  state_t        state_q, state_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_on_q, blink_on_d;
  logic          in_ready_q, accept_s, newline_s;
  logic          b_we_s;
  logic [AW-1:0] b_addr_s, a_addr_s, cur_addr_s;
  logic [7:0]    b_wdata_s, b_rdata_s, a_data_s;
  logic [9:0]    char_col_s, char_row_s;
  logic [3:0]    pix_col_s;
  logic          in_range_s, hit_s;
  logic [3:0]    font_row_q, font_col_q;
  logic          hit_q, blank_q, pv_q, rgb_valid_q;
  logic [23:0]   rgb_q, rgb_d;

  function automatic logic [AW-1:0] cell_addr(input logic [9:0] r, input logic [9:0] c);
    return AW'(int'(r) * COLS + int'(c));
  endfunction

  assign accept_s   = in_valid && in_ready_q;
  assign cur_addr_s = cell_addr(10'(row_q), 10'(col_q));

  // Controller: CLEAR sweep, character decode, scroll copy and fill.
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    cnt_d     = cnt_q;
    b_we_s    = 1'b0;
    b_addr_s  = cnt_q;
    b_wdata_s = CH_SPACE;
    newline_s = 1'b0;
    case (state_q)
      CLEAR, SC_FILL: begin
        b_we_s = 1'b1;
        if (cnt_q == LAST_CELL) begin
          cnt_d   = {AW{1'b0}};
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      IDLE: begin
        b_addr_s = cur_addr_s;
        if (accept_s) begin
          if (in_char >= CH_SPACE && in_char <= CH_PRINT_HI) begin
            b_we_s    = 1'b1;
            b_wdata_s = in_char;
            if (col_q == CW'(COLS - 1)) begin
              col_d     = {CW{1'b0}};
              newline_s = 1'b1;
            end else begin
              col_d = col_q + CW'(1);
            end
          end else if (in_char == CH_LF || in_char == CH_CR) begin
            col_d     = {CW{1'b0}};
            newline_s = 1'b1;
          end else if (in_char == CH_BS) begin
            // Both backspace cases land on the cell just before the cursor.
            b_addr_s = cur_addr_s - AW'(1);
            if (col_q != {CW{1'b0}}) begin
              col_d  = col_q - CW'(1);
              b_we_s = 1'b1;
            end else if (row_q != {RW{1'b0}}) begin
              row_d  = row_q - RW'(1);
              col_d  = CW'(COLS - 1);
              b_we_s = 1'b1;
            end else begin
              b_we_s = 1'b0;
            end
          end else begin
            b_we_s = 1'b0;
          end
          if (newline_s) begin
            if (row_q == RW'(ROWS - 1)) begin
              col_d   = {CW{1'b0}};
              cnt_d   = {AW{1'b0}};
              state_d = SC_RD;
            end else begin
              row_d = row_q + RW'(1);
            end
          end else begin
            row_d = row_d;
          end
        end else begin
          b_we_s = 1'b0;
        end
      end
      SC_RD: begin
        b_addr_s = cnt_q + AW'(COLS);
        state_d  = SC_WR;
      end
      SC_WR: begin
        b_we_s    = 1'b1;
        b_wdata_s = b_rdata_s;
        cnt_d     = cnt_q + AW'(1);
        if (cnt_q == SCROLL_LAST) begin
          state_d = SC_FILL;
        end else begin
          state_d = SC_RD;
        end
      end
      default: begin
        state_d = CLEAR;
        cnt_d   = {AW{1'b0}};
      end
    endcase
  end

  // Blink phase: free-running, restarted "on" by every accepted character.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blink_on_d  = blink_on_q;
    if (accept_s) begin
      blink_cnt_d = {BW{1'b0}};
      blink_on_d  = 1'b1;
    end else if (blink_cnt_q == BW'(BLINK_CYCLES - 1)) begin
      blink_cnt_d = {BW{1'b0}};
      blink_on_d  = ~blink_on_q;
    end else begin
      blink_cnt_d = blink_cnt_q + BW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= CLEAR;
      row_q       <= {RW{1'b0}};
      col_q       <= {CW{1'b0}};
      cnt_q       <= {AW{1'b0}};
      blink_cnt_q <= {BW{1'b0}};
      blink_on_q  <= 1'b1;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      cnt_q       <= cnt_d;
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
      in_ready_q  <= (state_d == IDLE);
    end
  end

  // Render S0: split pixel into cell/offset; off-screen columns read cell 0 of the row.
  always_comb begin
    char_col_s = h_addr / 10'(CELL_W);
    pix_col_s  = 4'(h_addr % 10'(CELL_W));
    char_row_s = {4'b0000, v_addr[9:4]};
    in_range_s = (h_addr < 10'(COLS * CELL_W));
    if (in_range_s) begin
      a_addr_s = cell_addr(char_row_s, char_col_s);
    end else begin
      a_addr_s = cell_addr(char_row_s, 10'd0);
    end
    hit_s = in_range_s && (char_row_s == 10'(row_q)) && (char_col_s == 10'(col_q));
  end

  always_comb begin
    rgb_d = BG_RGB;
    if (blank_q) begin
      rgb_d = BG_RGB;
    end else if (hit_q && (font_row_q[3:1] == 3'b111) && blink_on_q) begin
      rgb_d = FG_RGB;
    end else if (font_bit) begin
      rgb_d = FG_RGB;
    end else begin
      rgb_d = BG_RGB;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      font_row_q  <= 4'd0;
      font_col_q  <= 4'd0;
      hit_q       <= 1'b0;
      blank_q     <= 1'b1;
      pv_q        <= 1'b0;
      rgb_q       <= BG_RGB;
      rgb_valid_q <= 1'b0;
    end else begin
      font_row_q  <= v_addr[3:0];
      font_col_q  <= pix_col_s;
      hit_q       <= hit_s;
      blank_q     <= !(pix_valid && in_range_s);
      pv_q        <= pix_valid;
      rgb_q       <= rgb_d;
      rgb_valid_q <= pv_q;
    end
  end

  vga_text_buf #(.DEPTH(CELLS), .AW(AW)) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .a_addr_i  (a_addr_s),
    .a_data_o  (a_data_s),
    .b_addr_i  (b_addr_s),
    .b_we_i    (b_we_s),
    .b_wdata_i (b_wdata_s),
    .b_rdata_o (b_rdata_s)
  );

  assign in_ready   = in_ready_q;
  assign font_ascii = a_data_s;
  assign font_row   = font_row_q;
  assign font_col   = font_col_q;
  assign rgb        = rgb_q;
  assign rgb_valid  = rgb_valid_q;

endmodule

// File: tb/tb_vga_text_ctrl.sv
// Scoreboard bench for vga_text_ctrl with a behavioural console model and font ROM.
module tb_vga_text_ctrl;

  localparam int COLS = 70;
  localparam int ROWS = 30;
  localparam int BLINK = 4;
  localparam logic [23:0] FG = 24'hFFFFFF;
  localparam logic [23:0] BG = 24'h000000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_char = 8'h00;
  logic        in_ready;
  logic [9:0]  h_addr = 10'd0;
  logic [9:0]  v_addr = 10'd0;
  logic        pix_valid = 1'b0;
  logic [7:0]  font_ascii;
  logic [3:0]  font_row;
  logic [3:0]  font_col;
  logic        font_bit;
  logic [23:0] rgb;
  logic        rgb_valid;

  vga_text_ctrl #(.COLS(COLS), .ROWS(ROWS), .FG_RGB(FG), .BG_RGB(BG), .BLINK_CYCLES(BLINK)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_char(in_char), .in_ready(in_ready),
    .h_addr(h_addr), .v_addr(v_addr), .pix_valid(pix_valid),
    .font_ascii(font_ascii), .font_row(font_row), .font_col(font_col), .font_bit(font_bit),
    .rgb(rgb), .rgb_valid(rgb_valid)
  );

  always #5 clk = ~clk;

  // Font ROM model: space is blank, other glyphs use a diagonal bit pattern.
  function automatic logic font_fn(input logic [7:0] a, input logic [3:0] r, input logic [3:0] c);
    int idx;
    idx = (int'(r) + int'(c)) % 8;
    if (a == 8'h20) return 1'b0;
    return a[idx];
  endfunction

  always_comb font_bit = font_fn(font_ascii, font_row, font_col);

  int ecnt = 0;
  always @(posedge clk) ecnt <= ecnt + 1;

  int checks = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [23:0] rgb;
    logic [7:0]  asc;
    logic        chk_asc;
    logic [3:0]  row;
    logic [3:0]  col;
  } exp_t;

  exp_t sb_q[$];
  bit   mon_en = 1'b1;
  logic [7:0] p_asc = 8'h00;
  logic [3:0] p_row = 4'd0;
  logic [3:0] p_col = 4'd0;

  // Monitor: font_* are sampled one negedge before the matching rgb.
  always @(negedge clk) begin
    if (mon_en && rgb_valid) begin
      if (sb_q.size() == 0) begin
        check("unexpected_rgb_valid", 32'd1, 32'd0);
      end else begin
        check("rgb", rgb, sb_q[0].rgb);
        if (sb_q[0].chk_asc) check("font_ascii", p_asc, sb_q[0].asc);
        check("font_row", p_row, sb_q[0].row);
        check("font_col", p_col, sb_q[0].col);
        void'(sb_q.pop_front());
      end
    end
    p_asc <= font_ascii;
    p_row <= font_row;
    p_col <= font_col;
  end

  // Console model
  logic [7:0] scr [COLS*ROWS];
  int cr = 0, cc = 0, blink_e = 0;

  task automatic model_clear();
    for (int i = 0; i < COLS*ROWS; i++) scr[i] = 8'h20;
    cr = 0;
    cc = 0;
  endtask

  task automatic model_char(input logic [7:0] ch);
    bit nl;
    int a;
    nl = 1'b0;
    a = cr*COLS + cc;
    if (ch >= 8'h20 && ch <= 8'h7E) begin
      scr[a] = ch;
      if (cc == COLS-1) begin cc = 0; nl = 1'b1; end
      else cc++;
    end else if (ch == 8'h0A || ch == 8'h0D) begin
      cc = 0; nl = 1'b1;
    end else if (ch == 8'h08) begin
      if (cc > 0) begin cc--; scr[a-1] = 8'h20; end
      else if (cr > 0) begin cr--; cc = COLS-1; scr[a-1] = 8'h20; end
    end
    if (nl) begin
      if (cr == ROWS-1) begin
        cc = 0;
        for (int i = 0; i < (ROWS-1)*COLS; i++) scr[i] = scr[i+COLS];
        for (int i = (ROWS-1)*COLS; i < ROWS*COLS; i++) scr[i] = 8'h20;
      end else begin
        cr++;
      end
    end
  endtask

  // Blink phase after posedge number x.
  function automatic bit phase_on(input int x);
    int k;
    k = x - blink_e;
    return ((k / BLINK) % 2) == 0;
  endfunction

  task automatic send(input logic [7:0] ch);
    int n;
    logic rdy;
    int acc;
    n = 0;
    acc = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_char = ch;
    forever begin
      rdy = in_ready;
      acc = ecnt + 1;
      @(posedge clk);
      if (rdy) break;
      n++;
      if (n > 10000) begin
        check("send_timeout", 32'd0, 32'd1);
        break;
      end
      @(negedge clk);
    end
    model_char(ch);
    blink_e = acc;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic pix(input int h, input int v);
    exp_t e;
    int row, col;
    logic [7:0] ch;
    bit hit;
    @(negedge clk);
    h_addr = 10'(h);
    v_addr = 10'(v);
    pix_valid = 1'b1;
    row = v / 16;
    col = h / 9;
    e.row = 4'(v % 16);
    e.col = 4'(h % 9);
    if (h >= COLS*9) begin
      e.rgb = BG; e.asc = 8'h00; e.chk_asc = 1'b0;
    end else begin
      ch = scr[row*COLS + col];
      e.asc = ch;
      e.chk_asc = 1'b1;
      hit = (row == cr) && (col == cc) && (e.row >= 4'd14) && phase_on(ecnt + 1);
      e.rgb = (hit || font_fn(ch, e.row, e.col)) ? FG : BG;
    end
    sb_q.push_back(e);
  endtask

  task automatic scan(input int h0, input int h1, input int v0, input int v1);
    for (int v = v0; v <= v1; v++)
      for (int h = h0; h <= h1; h++)
        pix(h, v);
    @(negedge clk);
    pix_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic release_and_clear();
    int n;
    @(negedge clk);
    rst_n = 1'b1;
    blink_e = ecnt;
    model_clear();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 6000);
    check("clear_cycles", n, 32'd2100);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 32'd0);
    check("rst_rgb_valid", rgb_valid, 32'd0);
    check("rst_rgb", rgb, BG);
    check("rst_font_ascii", font_ascii, 32'd0);
    check("rst_font_row", font_row, 32'd0);
    check("rst_font_col", font_col, 32'd0);
    release_and_clear();
    scan(0, 17, 0, 15);

    send(8'h08);                        // backspace at (0,0): no effect
    scan(0, 8, 12, 15);

    send(8'h41);                        // 'A' -> cursor (0,1)
    scan(0, 17, 0, 15);

    for (int i = 1; i < COLS; i++) send(8'(8'h41 + (i % 26)));
    scan(621, 639, 0, 15);              // last cell and the unused 630..639 strip
    scan(0, 8, 16, 31);                 // cursor wrapped to (1,0)

    send(8'h08);                        // back to (0,69), cell blanked
    scan(621, 629, 0, 15);

    send(8'h5A);                        // 'Z' at (0,69) -> (1,0)
    send(8'h51);                        // 'Q' at (1,0)  -> (1,1)
    for (int i = 0; i < ROWS-2; i++) send(8'h0A);
    send(8'h0A);                        // newline on row 29 -> scroll
    n = 0;
    while (!in_ready && n < 6000) begin
      n++;
      @(negedge clk);
    end
    check("scroll_cycles", n, 32'd4130);
    scan(0, 17, 0, 15);                 // 'Q' now on row 0
    scan(0, 26, 464, 479);              // row 29 blank, cursor at (29,0)

    for (int i = 0; i < 20; i++) pix(0, 14);
    @(negedge clk); pix_valid = 1'b0; repeat (3) @(negedge clk);
    send(8'h78);                        // accepted char restarts blink phase
    for (int i = 0; i < 12; i++) pix(9, 15);
    @(negedge clk); pix_valid = 1'b0; repeat (3) @(negedge clk);

    send(8'h0A);                        // start another scroll
    repeat (100) @(negedge clk);
    check("in_ready_scroll", in_ready, 32'd0);
    mon_en = 1'b0;
    h_addr = 10'd0; v_addr = 10'd0; pix_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("rgb_valid_before_rst", rgb_valid, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midscroll_rgb_valid", rgb_valid, 32'd0);
    check("midscroll_rgb", rgb, BG);
    check("midscroll_in_ready", in_ready, 32'd0);
    check("midscroll_font_ascii", font_ascii, 32'd0);
    pix_valid = 1'b0;
    repeat (3) @(negedge clk);
    sb_q.delete();
    mon_en = 1'b1;
    release_and_clear();
    scan(0, 17, 0, 15);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
